// File: rtl/sipo_frame_ctrl.sv
// Serial-to-parallel framing controller: collects MSB-first words delimited by sof,
// presents them on a valid/ready holding register and flags resync, timeout and overrun.
module sipo_frame_ctrl #(
  parameter int WIDTH   = 8,
  parameter int TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             sdi,
  input  logic             sdi_valid,
  input  logic             sof,
  input  logic             ovr_clr,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             frame_err,
  output logic             overrun
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SHIFT = 1'b1;

  logic [0:0]       state;
  logic [WIDTH-1:0] shifter;
  logic [CNT_W-1:0] bit_cnt;
  logic [7:0]       idle_cnt;

  logic             start;
  logic             resync;
  logic             shift_in;
  logic             complete;
  logic             timeout;
  logic             hold_free;
  logic [WIDTH-1:0] word;

  // A sof on what would be the completing bit is a resync, so completion
  // is only considered for non-sof bits.
  always_comb begin
    start     = (state == ST_IDLE) && sdi_valid && sof;
    resync    = (state == ST_SHIFT) && sdi_valid && sof;
    shift_in  = (state == ST_SHIFT) && sdi_valid && !sof;
    complete  = shift_in && (bit_cnt == CNT_W'(WIDTH - 1));
    timeout   = (state == ST_SHIFT) && !sdi_valid && (idle_cnt == 8'(TIMEOUT - 1));
    hold_free = !out_valid || out_ready;
    word      = {shifter[WIDTH-2:0], sdi};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ST_IDLE;
      shifter  <= '0;
      bit_cnt  <= '0;
      idle_cnt <= '0;
    end else if (start || resync) begin
      state    <= ST_SHIFT;
      shifter  <= {{(WIDTH-1){1'b0}}, sdi};
      bit_cnt  <= CNT_W'(1);
      idle_cnt <= '0;
    end else if (complete) begin
      state    <= ST_IDLE;
      shifter  <= '0;
      bit_cnt  <= '0;
      idle_cnt <= '0;
    end else if (shift_in) begin
      shifter  <= word;
      bit_cnt  <= bit_cnt + CNT_W'(1);
      idle_cnt <= '0;
    end else if (timeout) begin
      state    <= ST_IDLE;
      shifter  <= '0;
      bit_cnt  <= '0;
      idle_cnt <= '0;
    end else if (state == ST_SHIFT) begin
      idle_cnt <= idle_cnt + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_data  <= '0;
      out_valid <= 1'b0;
    end else if (complete && hold_free) begin
      out_data  <= word;
      out_valid <= 1'b1;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // A fresh overrun on the same edge as ovr_clr keeps the flag set.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      overrun   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= resync || timeout;
      if (complete && !hold_free) begin
        overrun <= 1'b1;
      end else if (ovr_clr) begin
        overrun <= 1'b0;
      end
    end
  end

  assign busy = (state == ST_SHIFT);

endmodule

// File: tb/tb_sipo_frame_ctrl.sv
// Directed, table-driven bench for sipo_frame_ctrl (WIDTH=8, TIMEOUT=16) with
// hand-written sequences for asynchronous reset mid-frame.
module tb_sipo_frame_ctrl;

  logic       clk;
  logic       reset_n;
  logic       sdi;
  logic       sdi_valid;
  logic       sof;
  logic       ovr_clr;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       busy;
  logic       frame_err;
  logic       overrun;

  int n_checks = 0;
  int n_fail   = 0;

  sipo_frame_ctrl #(.WIDTH(8), .TIMEOUT(16)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .sdi       (sdi),
    .sdi_valid (sdi_valid),
    .sof       (sof),
    .ovr_clr   (ovr_clr),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy),
    .frame_err (frame_err),
    .overrun   (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       sdi;
    logic       vld;
    logic       sof;
    logic       rdy;
    logic       clr;
    logic       ev;
    logic [7:0] ed;
    logic       eb;
    logic       ee;
    logic       eo;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic s, input logic v, input logic f, input logic r, input logic c,
                     input logic ev, input logic [7:0] ed, input logic eb, input logic ee,
                     input logic eo);
    vec_t x;
    x.sdi = s; x.vld = v; x.sof = f; x.rdy = r; x.clr = c;
    x.ev = ev; x.ed = ed; x.eb = eb; x.ee = ee; x.eo = eo;
    vecs.push_back(x);
  endtask

  // Eight consecutive bits, sof on the first; expectations given for the
  // seven in-frame cycles and for the cycle after the completing bit.
  task automatic add_frame(input logic [7:0] w, input logic rdy, input logic rdy_last,
                           input logic ev_mid, input logic [7:0] ed_mid, input logic eo_mid,
                           input logic ev_end, input logic [7:0] ed_end, input logic eo_end);
    for (int i = 0; i < 8; i++) begin
      if (i < 7) add(w[7-i], 1'b1, (i == 0), rdy, 1'b0, ev_mid, ed_mid, 1'b1, 1'b0, eo_mid);
      else       add(w[7-i], 1'b1, 1'b0, rdy_last, 1'b0, ev_end, ed_end, 1'b0, 1'b0, eo_end);
    end
  endtask

  task automatic chk(input string name, input int idx, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s (step %0d): got 0x%0h, expected 0x%0h", name, idx, got, exp);
    end
  endtask

  task automatic drive(input logic s, input logic v, input logic f, input logic r, input logic c);
    sdi = s; sdi_valid = v; sof = f; out_ready = r; ovr_clr = c;
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [7:0] w, input logic r);
    for (int i = 0; i < 8; i++) drive(w[7-i], 1'b1, (i == 0), r, 1'b0);
  endtask

  initial begin
    // Reset / idle / discarded bits in IDLE
    add(0, 0, 0, 1, 0, 0, 8'h00, 0, 0, 0);
    add(1, 1, 0, 1, 0, 0, 8'h00, 0, 0, 0);
    add(1, 1, 0, 1, 0, 0, 8'h00, 0, 0, 0);
    // Basic frame 0xB2, consumer ready
    add_frame(8'hB2, 1, 1, 0, 8'h00, 0, 1, 8'hB2, 0);
    add(0, 0, 0, 1, 0, 0, 8'hB2, 0, 0, 0);
    // Back-to-back 0xA5, 0x3C with no consumer -> overrun, then clear
    add_frame(8'hA5, 0, 0, 0, 8'hB2, 0, 1, 8'hA5, 0);
    add_frame(8'h3C, 0, 0, 1, 8'hA5, 0, 1, 8'hA5, 1);
    add(0, 0, 0, 0, 1, 1, 8'hA5, 0, 0, 0);
    add(0, 0, 0, 0, 0, 1, 8'hA5, 0, 0, 0);
    // Drain and reload on the same edge
    add_frame(8'h3C, 0, 1, 1, 8'hA5, 0, 1, 8'h3C, 0);
    add(0, 0, 0, 1, 0, 0, 8'h3C, 0, 0, 0);
    // Resync on bit 5, then 0x0F
    add(1, 1, 1, 1, 0, 0, 8'h3C, 1, 0, 0);
    add(1, 1, 0, 1, 0, 0, 8'h3C, 1, 0, 0);
    add(0, 1, 0, 1, 0, 0, 8'h3C, 1, 0, 0);
    add(1, 1, 0, 1, 0, 0, 8'h3C, 1, 0, 0);
    add(0, 1, 1, 1, 0, 0, 8'h3C, 1, 1, 0);
    for (int i = 0; i < 6; i++) add((i >= 3), 1, 0, 1, 0, 0, 8'h3C, 1, 0, 0);
    add(1, 1, 0, 1, 0, 1, 8'h0F, 0, 0, 0);
    add(0, 0, 0, 1, 0, 0, 8'h0F, 0, 0, 0);
    // sof on the would-be completing bit is a resync; new word 0x55
    add(1, 1, 1, 1, 0, 0, 8'h0F, 1, 0, 0);
    for (int i = 0; i < 6; i++) add(1, 1, 0, 1, 0, 0, 8'h0F, 1, 0, 0);
    add(0, 1, 1, 1, 0, 0, 8'h0F, 1, 1, 0);
    for (int i = 0; i < 6; i++) add(~i[0], 1, 0, 1, 0, 0, 8'h0F, 1, 0, 0);
    add(1, 1, 0, 1, 0, 1, 8'h55, 0, 0, 0);
    add(0, 0, 0, 1, 0, 0, 8'h55, 0, 0, 0);
    // Timeout after 3 bits and 16 idle cycles, then 0xFF
    add(1, 1, 1, 1, 0, 0, 8'h55, 1, 0, 0);
    add(0, 1, 0, 1, 0, 0, 8'h55, 1, 0, 0);
    add(1, 1, 0, 1, 0, 0, 8'h55, 1, 0, 0);
    for (int i = 0; i < 15; i++) add(0, 0, 0, 1, 0, 0, 8'h55, 1, 0, 0);
    add(0, 0, 0, 1, 0, 0, 8'h55, 0, 1, 0);
    add(0, 0, 0, 1, 0, 0, 8'h55, 0, 0, 0);
    add_frame(8'hFF, 1, 1, 0, 8'h55, 0, 1, 8'hFF, 0);
    add(0, 0, 0, 1, 0, 0, 8'hFF, 0, 0, 0);

    reset_n = 1'b0;
    sdi = 0; sdi_valid = 0; sof = 0; out_ready = 0; ovr_clr = 0;
    #12;
    chk("reset out_valid", -1, {7'd0, out_valid}, 8'h00);
    chk("reset out_data", -1, out_data, 8'h00);
    chk("reset busy", -1, {7'd0, busy}, 8'h00);
    chk("reset frame_err", -1, {7'd0, frame_err}, 8'h00);
    chk("reset overrun", -1, {7'd0, overrun}, 8'h00);
    reset_n = 1'b1;

    foreach (vecs[i]) begin
      drive(vecs[i].sdi, vecs[i].vld, vecs[i].sof, vecs[i].rdy, vecs[i].clr);
      chk("out_valid", i, {7'd0, out_valid}, {7'd0, vecs[i].ev});
      chk("out_data", i, out_data, vecs[i].ed);
      chk("busy", i, {7'd0, busy}, {7'd0, vecs[i].eb});
      chk("frame_err", i, {7'd0, frame_err}, {7'd0, vecs[i].ee});
      chk("overrun", i, {7'd0, overrun}, {7'd0, vecs[i].eo});
    end

    // Asynchronous reset mid-frame with a held word and overrun set
    send_word(8'h12, 1'b0);
    send_word(8'h34, 1'b0);
    drive(1, 1, 1, 0, 0);
    drive(0, 1, 0, 0, 0);
    chk("pre-reset out_valid", 0, {7'd0, out_valid}, 8'h01);
    chk("pre-reset out_data", 0, out_data, 8'h12);
    chk("pre-reset overrun", 0, {7'd0, overrun}, 8'h01);
    chk("pre-reset busy", 0, {7'd0, busy}, 8'h01);
    sdi_valid = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    chk("async reset out_valid", 0, {7'd0, out_valid}, 8'h00);
    chk("async reset out_data", 0, out_data, 8'h00);
    chk("async reset busy", 0, {7'd0, busy}, 8'h00);
    chk("async reset overrun", 0, {7'd0, overrun}, 8'h00);
    chk("async reset frame_err", 0, {7'd0, frame_err}, 8'h00);
    #1 reset_n = 1'b1;
    send_word(8'h81, 1'b1);
    chk("post-reset out_valid", 0, {7'd0, out_valid}, 8'h01);
    chk("post-reset out_data", 0, out_data, 8'h81);
    chk("post-reset busy", 0, {7'd0, busy}, 8'h00);
    chk("post-reset overrun", 0, {7'd0, overrun}, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sipo_frame_ctrl.md
# sipo_frame_ctrl

Framing controller for the serial-to-parallel capture path. Sequences a WIDTH-bit MSB-first shift register from a strobed serial stream and uses a start-of-frame marker to delimit words. Each completed word moves into an output holding register, presented on a valid/ready interface. Sits between a serial front end and any parallel consumer, and flags resync, timeout and overrun conditions.

## Interface
- WIDTH, 8, word length in bits; legal range 2..32.
- TIMEOUT, 16, max cycles without sdi_valid inside a frame before abort; legal range 2..255.
- clk  input  1  clock, all state on rising edge.
- reset_n  input  1  reset, asynchronous, active-low.
- sdi  input  1  serial data bit.
- sdi_valid  input  1  sdi is sampled on the edges where this is 1.
- sof  input  1  qualified by sdi_valid; marks the current bit as bit 0 (MSB) of a word.
- ovr_clr  input  1  clears the sticky overrun flag.
- out_data  output  WIDTH  completed word, MSB = first received bit.
- out_valid  output  1  out_data holds an unconsumed word.
- out_ready  input  1  consumer accepts out_data on edges where out_valid && out_ready.
- busy  output  1  high while a frame is partially collected (state SHIFT).
- frame_err  output  1  one-cycle pulse on resync or timeout abort.
- overrun  output  1  sticky; set when a completed word is dropped.

## Operation
- Reset: state IDLE; shifter, bit count and idle timer 0; out_data 0; out_valid 0; busy 0; frame_err 0; overrun 0.
- Shift rule: on each accepted bit, shifter <= {shifter[WIDTH-2:0], sdi}, and bit count increments.
- IDLE:
  - sdi_valid && sof: load sdi as bit 0, count = 1, go to SHIFT.
  - sdi_valid && !sof: bit discarded, no error.
- SHIFT:
  - sdi_valid && !sof: shift the bit in and clear the idle timer.
  - sdi_valid && sof (resync): discard the partial word, restart with this bit as bit 0 (count = 1), and pulse frame_err.
  - !sdi_valid: the idle timer increments. When it reaches TIMEOUT, discard the partial word, pulse frame_err and go to IDLE.
- Completion: the accepted bit that makes count == WIDTH completes the word. The completed word is {shifter[WIDTH-2:0], sdi}. State returns to IDLE and the count clears.
  - If the holding register is free (out_valid == 0), or is being drained on the same edge (out_valid && out_ready), load out_data and set out_valid.
  - Otherwise drop the word, keep the held out_data, and set overrun.
- A sof arriving on a completing bit for WIDTH > 1 counts as resync and takes priority: no completion.
- overrun:
  - Cleared by ovr_clr.
  - If a new overrun and ovr_clr occur on the same edge, set wins.
- out_data is stable while out_valid && !out_ready.

## Timing
- Latency: the last bit is sampled on edge N. out_valid = 1 and out_data are valid after edge N, so both are visible in the cycle following edge N.
- Back-to-back: a new sof may arrive on the cycle immediately after completion. There are no dead cycles.
- Minimum word spacing is WIDTH accepted bits. With out_ready held at 1, there are no overruns at full rate.
- out_valid falls after an accept edge unless a completing word loads on that same edge, in which case it stays 1 with new data.
- frame_err is high exactly one cycle after the causing edge.
- Reset asserted mid-frame or with out_valid = 1: all outputs return to reset values immediately. The partial or held word is lost.

## Test plan
- WIDTH=8. Bits 1,0,1,1,0,0,1,0 on consecutive cycles, sof on the first, out_ready=1 -> out_data=0xB2 with out_valid high one cycle after the 8th bit; busy high for 7 cycles.
- Two back-to-back frames 0xA5 then 0x3C with out_ready=0 throughout -> out_data stays 0xA5 and overrun=1 after the 2nd frame completes. Then ovr_clr=1 -> overrun=0.
- Frame 0xA5 held unaccepted; out_ready pulsed on the same edge as 0x3C completes -> out_valid stays 1, out_data=0x3C, overrun=0.
- sof re-asserted on bit 5 of a frame, followed by 8 bits of 0x0F -> one frame_err pulse, then out_data=0x0F; no word emitted for the aborted frame.
- TIMEOUT=16. 3 bits accepted, then sdi_valid=0 for 16 cycles -> frame_err pulse, busy=0, no out_valid. A following full frame 0xFF is received correctly.
- reset_n pulsed low asynchronously mid-frame with out_valid=1 -> out_valid, busy, overrun and out_data all 0 immediately. The next sof frame 0x81 is captured normally.
